// File: rtl/pulp_io_l2_pkg.sv
// Shared types and constants for the IO subsystem L2 port merge logic.
package pulp_io_l2_pkg;

  localparam int L2_ADDR_WIDTH = 32;
  localparam int L2_DATA_WIDTH = 32;

  typedef enum logic {
    SRC_RO = 1'b0,
    SRC_WO = 1'b1
  } l2_src_e;

  typedef struct packed {
    logic [L2_ADDR_WIDTH-1:0]   addr;
    logic                       wen;
    logic [L2_DATA_WIDTH/8-1:0] be;
    logic [L2_DATA_WIDTH-1:0]   wdata;
  } l2_req_t;

endpackage

// File: rtl/pulp_io_l2_id_fifo.sv
// In-order queue of 1-bit source IDs for granted L2 transactions awaiting rvalid.
module pulp_io_l2_id_fifo #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          push_id,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic          head,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_id;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pulp_io_l2_port_mux.sv
// Merges the uDMA read-only and write-only L2 ports onto one TCDM master port
// with locking round-robin arbitration and in-order response routing.
module pulp_io_l2_port_mux
  import pulp_io_l2_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  localparam int BE_W = DATA_WIDTH / 8,
  localparam int CW   = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                     sys_clk_i,
  input  logic                     sys_rst_ni,

  input  logic                     ro_req_i,
  output logic                     ro_gnt_o,
  input  logic [L2_ADDR_WIDTH-1:0] ro_addr_i,
  input  logic                     ro_wen_i,
  input  logic [BE_W-1:0]          ro_be_i,
  input  logic [DATA_WIDTH-1:0]    ro_wdata_i,
  output logic                     ro_rvalid_o,
  output logic [DATA_WIDTH-1:0]    ro_rdata_o,

  input  logic                     wo_req_i,
  output logic                     wo_gnt_o,
  input  logic [L2_ADDR_WIDTH-1:0] wo_addr_i,
  input  logic                     wo_wen_i,
  input  logic [BE_W-1:0]          wo_be_i,
  input  logic [DATA_WIDTH-1:0]    wo_wdata_i,
  output logic                     wo_rvalid_o,
  output logic [DATA_WIDTH-1:0]    wo_rdata_o,

  output logic                     l2_req_o,
  input  logic                     l2_gnt_i,
  output logic [L2_ADDR_WIDTH-1:0] l2_addr_o,
  output logic                     l2_wen_o,
  output logic [BE_W-1:0]          l2_be_o,
  output logic [DATA_WIDTH-1:0]    l2_wdata_o,
  input  logic                     l2_rvalid_i,
  input  logic [DATA_WIDTH-1:0]    l2_rdata_i,

  output logic [CW-1:0]            outstanding_o,
  output logic                     err_o
);

  // Same layout as l2_req_t, but sized by this instance's DATA_WIDTH.
  typedef struct packed {
    logic [L2_ADDR_WIDTH-1:0] addr;
    logic                     wen;
    logic [BE_W-1:0]          be;
    logic [DATA_WIDTH-1:0]    wdata;
  } port_req_t;

  l2_src_e   rr_ptr_q, lock_src_q, sel;
  logic      lock_q;
  logic      fifo_full, fifo_empty, fifo_head;
  logic      transfer, pop;
  port_req_t ro_req, wo_req, mst_req;

  assign ro_req = '{addr: ro_addr_i, wen: ro_wen_i, be: ro_be_i, wdata: ro_wdata_i};
  assign wo_req = '{addr: wo_addr_i, wen: wo_wen_i, be: wo_be_i, wdata: wo_wdata_i};

  always_comb begin
    sel = SRC_RO;
    if (lock_q)                    sel = lock_src_q;
    else if (ro_req_i && wo_req_i) sel = rr_ptr_q;
    else if (wo_req_i)             sel = SRC_WO;
  end

  // full comes from registered occupancy only; a same-cycle pop never unblocks.
  assign l2_req_o = (ro_req_i | wo_req_i) & ~fifo_full;
  assign transfer = l2_req_o & l2_gnt_i;
  assign ro_gnt_o = transfer & (sel == SRC_RO);
  assign wo_gnt_o = transfer & (sel == SRC_WO);

  assign mst_req    = (sel == SRC_WO) ? wo_req : ro_req;
  assign l2_addr_o  = mst_req.addr;
  assign l2_wen_o   = mst_req.wen;
  assign l2_be_o    = mst_req.be;
  assign l2_wdata_o = mst_req.wdata;

  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) begin
      rr_ptr_q   <= SRC_RO;
      lock_q     <= 1'b0;
      lock_src_q <= SRC_RO;
      err_o      <= 1'b0;
    end else begin
      if (transfer) begin
        lock_q   <= 1'b0;
        rr_ptr_q <= (sel == SRC_RO) ? SRC_WO : SRC_RO;
      end else if (l2_req_o) begin
        lock_q     <= 1'b1;
        lock_src_q <= sel;
      end
      if (l2_rvalid_i && fifo_empty) err_o <= 1'b1;
    end
  end

  assign pop = l2_rvalid_i & ~fifo_empty;

  pulp_io_l2_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .CW    (CW)
  ) u_id_fifo (
    .clk     (sys_clk_i),
    .rst_n   (sys_rst_ni),
    .push    (transfer),
    .push_id (sel == SRC_WO),
    .pop     (pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head),
    .count   (outstanding_o)
  );

  assign ro_rvalid_o = pop & ~fifo_head;
  assign wo_rvalid_o = pop &  fifo_head;
  assign ro_rdata_o  = l2_rdata_i;
  assign wo_rdata_o  = l2_rdata_i;

endmodule

// File: tb/tb_pulp_io_l2_port_mux.sv
// Directed bench for pulp_io_l2_port_mux: routing, arbitration, lock, backpressure, errors.
module tb_pulp_io_l2_port_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ro_req, ro_gnt, ro_wen, ro_rvalid;
  logic [31:0] ro_addr, ro_wdata, ro_rdata;
  logic [3:0]  ro_be;
  logic        wo_req, wo_gnt, wo_wen, wo_rvalid;
  logic [31:0] wo_addr, wo_wdata, wo_rdata;
  logic [3:0]  wo_be;
  logic        l2_req, l2_gnt, l2_wen, l2_rvalid;
  logic [31:0] l2_addr, l2_wdata, l2_rdata;
  logic [3:0]  l2_be;
  logic [2:0]  outstanding;
  logic        err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pulp_io_l2_port_mux #(.DATA_WIDTH(32), .MAX_OUTSTANDING(4)) dut (
    .sys_clk_i(clk), .sys_rst_ni(rst_n),
    .ro_req_i(ro_req), .ro_gnt_o(ro_gnt), .ro_addr_i(ro_addr), .ro_wen_i(ro_wen),
    .ro_be_i(ro_be), .ro_wdata_i(ro_wdata), .ro_rvalid_o(ro_rvalid), .ro_rdata_o(ro_rdata),
    .wo_req_i(wo_req), .wo_gnt_o(wo_gnt), .wo_addr_i(wo_addr), .wo_wen_i(wo_wen),
    .wo_be_i(wo_be), .wo_wdata_i(wo_wdata), .wo_rvalid_o(wo_rvalid), .wo_rdata_o(wo_rdata),
    .l2_req_o(l2_req), .l2_gnt_i(l2_gnt), .l2_addr_o(l2_addr), .l2_wen_o(l2_wen),
    .l2_be_o(l2_be), .l2_wdata_o(l2_wdata), .l2_rvalid_i(l2_rvalid), .l2_rdata_i(l2_rdata),
    .outstanding_o(outstanding), .err_o(err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ro_req = 0; wo_req = 0; l2_gnt = 0; l2_rvalid = 0; l2_rdata = '0;
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    ro_addr = 32'h0; ro_wen = 1; ro_be = 4'hF; ro_wdata = 32'h0;
    wo_addr = 32'h0; wo_wen = 0; wo_be = 4'h3; wo_wdata = 32'h0;
    rst_n = 1'b0; ro_req = 0; wo_req = 0; l2_gnt = 0; l2_rvalid = 0; l2_rdata = '0;
    tick();
    check("rst_l2_req", l2_req, 0);
    check("rst_gnts", {ro_gnt, wo_gnt}, 0);
    check("rst_rvalids", {ro_rvalid, wo_rvalid}, 0);
    check("rst_outstanding", outstanding, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    tick();

    // single RO read
    ro_req = 1; ro_addr = 32'h1C00_0000; l2_gnt = 1;
    #1;
    check("rd_l2_req", l2_req, 1);
    check("rd_ro_gnt", ro_gnt, 1);
    check("rd_wo_gnt", wo_gnt, 0);
    check("rd_addr", l2_addr, 32'h1C00_0000);
    check("rd_wen", l2_wen, 1);
    tick();
    ro_req = 0; l2_gnt = 0;
    check("rd_out1", outstanding, 1);
    l2_rvalid = 1; l2_rdata = 32'hDEAD_BEEF;
    #1;
    check("rd_ro_rvalid", ro_rvalid, 1);
    check("rd_wo_rvalid", wo_rvalid, 0);
    check("rd_rdata", ro_rdata, 32'hDEAD_BEEF);
    tick();
    l2_rvalid = 0;
    check("rd_out0", outstanding, 0);
    check("rd_no_err", err, 0);

    // contention from reset: RO, WO, RO, WO
    do_reset();
    ro_req = 1; wo_req = 1; ro_addr = 32'hA0; wo_addr = 32'hB0; wo_wdata = 32'h1234; l2_gnt = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("ct_ro_gnt", ro_gnt, (i % 2 == 0));
      check("ct_wo_gnt", wo_gnt, (i % 2 == 1));
      check("ct_addr", l2_addr, (i % 2 == 0) ? 32'hA0 : 32'hB0);
      tick();
    end
    ro_req = 0; wo_req = 0; l2_gnt = 0;
    check("ct_out4", outstanding, 4);
    for (int i = 0; i < 4; i++) begin
      l2_rvalid = 1; l2_rdata = 32'h100 + i;
      #1;
      check("ct_ro_rvalid", ro_rvalid, (i % 2 == 0));
      check("ct_wo_rvalid", wo_rvalid, (i % 2 == 1));
      check("ct_wo_rdata", wo_rdata, 32'h100 + i);
      tick();
    end
    l2_rvalid = 0;
    check("ct_out0", outstanding, 0);

    // lock: gnt low for 3 cycles keeps RO selected
    do_reset();
    ro_req = 1; wo_req = 1; l2_gnt = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("lk_req", l2_req, 1);
      check("lk_addr", l2_addr, 32'hA0);
      check("lk_wo_gnt", wo_gnt, 0);
      tick();
    end
    l2_gnt = 1;
    #1;
    check("lk_ro_gnt", ro_gnt, 1);
    tick();
    check("lk_wo_gnt_next", wo_gnt, 1);
    check("lk_wo_addr", l2_addr, 32'hB0);
    check("lk_wo_data", l2_wdata, 32'h1234);
    check("lk_wo_be", l2_be, 4'h3);
    tick();
    ro_req = 0; wo_req = 0; l2_gnt = 0;
    check("pp_out2", outstanding, 2);

    // simultaneous push/pop at occupancy 2 (queue RO,WO)
    ro_req = 1; l2_gnt = 1; l2_rvalid = 1;
    #1;
    check("pp_ro_rvalid", ro_rvalid, 1);
    tick();
    ro_req = 0; l2_rvalid = 0;
    check("pp_out_same", outstanding, 2);
    // queue now WO,RO; add WO then RO to fill
    wo_req = 1;
    tick();
    wo_req = 0; ro_req = 1;
    tick();
    ro_req = 0; l2_gnt = 0;
    check("pp_out4", outstanding, 4);
    for (int i = 0; i < 4; i++) begin
      l2_rvalid = 1;
      #1;
      check("pp_wo_rvalid", wo_rvalid, (i % 2 == 0));
      check("pp_ro_rvalid_seq", ro_rvalid, (i % 2 == 1));
      tick();
    end
    l2_rvalid = 0;
    check("pp_out_empty", outstanding, 0);

    // backpressure: four grants then blocked until a pop lands
    do_reset();
    ro_req = 1; l2_gnt = 1;
    repeat (4) tick();
    check("bp_out4", outstanding, 4);
    check("bp_req_blocked", l2_req, 0);
    check("bp_gnt_blocked", ro_gnt, 0);
    l2_rvalid = 1;
    #1;
    check("bp_same_cycle_pop", l2_req, 0);
    tick();
    l2_rvalid = 0;
    check("bp_out3", outstanding, 3);
    check("bp_req_unblocked", l2_req, 1);
    ro_req = 0; l2_gnt = 0;

    // spurious rvalid with empty queue
    do_reset();
    l2_rvalid = 1; l2_rdata = 32'h5555_AAAA;
    #1;
    check("er_rvalids", {ro_rvalid, wo_rvalid}, 0);
    check("er_not_yet", err, 0);
    tick();
    l2_rvalid = 0;
    check("er_set", err, 1);
    check("er_out", outstanding, 0);
    repeat (3) tick();
    check("er_sticky", err, 1);
    rst_n = 1'b0;
    #1;
    check("er_cleared", err, 0);
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
